// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: collects results from NUM_SRC execution sources and grants
// up to two distinct-register writes per cycle onto the register file's two write
// ports. Grants are round-robin from rr_ptr. Port outputs are registered.
module regfile_wb_arbiter #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SRC-1:0]      req_valid,
  output logic [NUM_SRC-1:0]      req_ready,
  input  logic [NUM_SRC*5-1:0]    req_addr,
  input  logic [NUM_SRC*32-1:0]   req_data,
  output logic                    we1,
  output logic [4:0]              waddr1,
  output logic [31:0]             wdata1,
  output logic                    we2,
  output logic [4:0]              waddr2,
  output logic [31:0]             wdata2,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [PTR_W-1:0] rr_ptr;

  logic [AW-1:0]    addr_arr [NUM_SRC];
  logic [DW-1:0]    data_arr [NUM_SRC];

  logic             a_found_c;
  logic             b_found_c;
  logic [PTR_W-1:0] a_idx_c;
  logic [PTR_W-1:0] b_idx_c;
  logic [AW-1:0]    a_addr_c;
  logic [PTR_W-1:0] scan_idx_c;
  logic [AW-1:0]    scan_addr_c;
  logic [NUM_SRC-1:0] grant_c;
  logic [NUM_SRC-1:0] block_c;
  logic             stall_c;

  // Next round-robin position after a given source index.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] idx);
    return PTR_W'((32'(idx) + 32'd1) % NUM_SRC);
  endfunction

  // Per-source unpacking plus ready/blocked decode.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign addr_arr[g] = req_addr[g*AW +: AW];
    assign data_arr[g] = req_data[g*DW +: DW];
    assign grant_c[g]  = req_valid[g] && !rst &&
                         ((addr_arr[g] == '0) ||
                          (a_found_c && (a_idx_c == PTR_W'(g))) ||
                          (b_found_c && (b_idx_c == PTR_W'(g))));
    assign block_c[g]  = req_valid[g] && (addr_arr[g] != '0) && !grant_c[g];
  end

  assign req_ready = grant_c;
  assign stall_c   = (|block_c) && !rst;

  // Scan from rr_ptr: slot A is the first nonzero request, slot B the next one
  // with a different destination, so the two ports never collide.
  always_comb begin
    a_found_c   = 1'b0;
    b_found_c   = 1'b0;
    a_idx_c     = '0;
    b_idx_c     = '0;
    a_addr_c    = '0;
    scan_idx_c  = '0;
    scan_addr_c = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      scan_idx_c  = PTR_W'((32'(rr_ptr) + k) % NUM_SRC);
      scan_addr_c = addr_arr[scan_idx_c];
      if (req_valid[scan_idx_c] && (scan_addr_c != '0)) begin
        if (!a_found_c) begin
          a_found_c = 1'b1;
          a_idx_c   = scan_idx_c;
          a_addr_c  = scan_addr_c;
        end else if (!b_found_c && (scan_addr_c != a_addr_c)) begin
          b_found_c = 1'b1;
          b_idx_c   = scan_idx_c;
        end
      end
    end
  end

  // Register granted writes, advance the pointer and count stalled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      we1       <= 1'b0;
      waddr1    <= '0;
      wdata1    <= '0;
      we2       <= 1'b0;
      waddr2    <= '0;
      wdata2    <= '0;
      rr_ptr    <= '0;
      stall_cnt <= '0;
    end else begin
      we1 <= a_found_c;
      we2 <= b_found_c;
      if (a_found_c) begin
        waddr1 <= a_addr_c;
        wdata1 <= data_arr[a_idx_c];
      end
      if (b_found_c) begin
        waddr2 <= addr_arr[b_idx_c];
        wdata2 <= data_arr[b_idx_c];
      end
      if (b_found_c) begin
        rr_ptr <= ptr_inc(b_idx_c);
      end else if (a_found_c) begin
        rr_ptr <= ptr_inc(a_idx_c);
      end
      if (stall_c && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a small register-file model.
module tb_regfile_wb_arbiter;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned CNT_W   = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_SRC-1:0]    req_valid;
  logic [NUM_SRC-1:0]    req_ready;
  logic [NUM_SRC*5-1:0]  req_addr;
  logic [NUM_SRC*32-1:0] req_data;
  logic                  we1;
  logic [4:0]            waddr1;
  logic [31:0]           wdata1;
  logic                  we2;
  logic [4:0]            waddr2;
  logic [31:0]           wdata2;
  logic [CNT_W-1:0]      stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] rf [32];

  regfile_wb_arbiter #(.NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .we1       (we1),
    .waddr1    (waddr1),
    .wdata1    (wdata1),
    .we2       (we2),
    .waddr2    (waddr2),
    .wdata2    (wdata2),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  // Register file model: port 1 wins on a same-address collision.
  always @(posedge clk) begin
    if (we2) rf[waddr2] <= wdata2;
    if (we1) rf[waddr1] <= wdata1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_inv();
    if (we1 === 1'b1 && we2 === 1'b1) begin
      chk("inv_distinct", 64'(waddr1 != waddr2), 64'd1);
      chk("inv_nonzero", 64'((waddr1 != 5'd0) && (waddr2 != 5'd0)), 64'd1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk_inv();
  endtask

  task automatic set_src(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
    req_valid[i]        = v;
    req_addr[i*5 +: 5]  = a;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic chk_p1(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we1"}, 64'(we1), 64'(we));
    chk({tag, "_waddr1"}, 64'(waddr1), 64'(a));
    chk({tag, "_wdata1"}, 64'(wdata1), 64'(d));
  endtask

  task automatic chk_p2(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we2"}, 64'(we2), 64'(we));
    chk({tag, "_waddr2"}, 64'(waddr2), 64'(a));
    chk({tag, "_wdata2"}, 64'(wdata2), 64'(d));
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we1", 64'(we1), 64'd0);
    chk("rst_we2", 64'(we2), 64'd0);
    chk("rst_waddr1", 64'(waddr1), 64'd0);
    chk("rst_wdata2", 64'(wdata2), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    chk("rst_rr", 64'(dut.rr_ptr), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;

    // Four sources, distinct addresses, from rr_ptr=0
    set_src(0, 1'b1, 5'd1, 32'hA0);
    set_src(1, 1'b1, 5'd2, 32'hA1);
    set_src(2, 1'b1, 5'd3, 32'hA2);
    set_src(3, 1'b1, 5'd4, 32'hA3);
    #1 chk("four_c0_ready", 64'(req_ready), 64'b0011);
    tick();
    chk_p1("four_c0", 1'b1, 5'd1, 32'hA0);
    chk_p2("four_c0", 1'b1, 5'd2, 32'hA1);
    chk("four_c0_rr", 64'(dut.rr_ptr), 64'd2);
    chk("four_c0_stall", 64'(stall_cnt), 64'd1);
    set_src(0, 1'b0, 5'd0, 32'h0);
    set_src(1, 1'b0, 5'd0, 32'h0);
    #1 chk("four_c1_ready", 64'(req_ready), 64'b1100);
    tick();
    chk_p1("four_c1", 1'b1, 5'd3, 32'hA2);
    chk_p2("four_c1", 1'b1, 5'd4, 32'hA3);
    chk("four_c1_rr", 64'(dut.rr_ptr), 64'd0);
    chk("four_c1_stall", 64'(stall_cnt), 64'd1);
    set_src(2, 1'b0, 5'd0, 32'h0);
    set_src(3, 1'b0, 5'd0, 32'h0);
    tick();
    chk_p1("idle_hold", 1'b0, 5'd3, 32'hA2);
    chk("idle_we2", 64'(we2), 64'd0);
    chk("idle_rr", 64'(dut.rr_ptr), 64'd0);

    // Single source
    set_src(2, 1'b1, 5'd5, 32'hDEADBEEF);
    #1 chk("single_ready", 64'(req_ready), 64'b0100);
    tick();
    chk_p1("single", 1'b1, 5'd5, 32'hDEADBEEF);
    chk_p2("single_hold", 1'b0, 5'd4, 32'hA3);
    chk("single_rr", 64'(dut.rr_ptr), 64'd3);
    set_src(2, 1'b0, 5'd0, 32'h0);

    // Same-address conflict, rr_ptr=3 so src0 is scanned before src1
    set_src(0, 1'b1, 5'd7, 32'h11);
    set_src(1, 1'b1, 5'd7, 32'h22);
    #1 chk("same_c0_ready", 64'(req_ready), 64'b0001);
    tick();
    chk_p1("same_c0", 1'b1, 5'd7, 32'h11);
    chk("same_c0_we2", 64'(we2), 64'd0);
    chk("same_c0_rr", 64'(dut.rr_ptr), 64'd1);
    chk("same_c0_stall", 64'(stall_cnt), 64'd2);
    set_src(0, 1'b0, 5'd0, 32'h0);
    #1 chk("same_c1_ready", 64'(req_ready), 64'b0010);
    tick();
    chk_p1("same_c1", 1'b1, 5'd7, 32'h22);
    chk("same_c1_we2", 64'(we2), 64'd0);
    chk("same_c1_rr", 64'(dut.rr_ptr), 64'd2);
    set_src(1, 1'b0, 5'd0, 32'h0);
    tick();
    chk("same_rf7", 64'(rf[7]), 64'h22);

    // Address-0 discard, rr_ptr=2
    set_src(0, 1'b1, 5'd0, 32'h55);
    set_src(1, 1'b1, 5'd9, 32'h99);
    #1 chk("zero_ready", 64'(req_ready), 64'b0011);
    tick();
    chk_p1("zero", 1'b1, 5'd9, 32'h99);
    chk("zero_we2", 64'(we2), 64'd0);
    chk("zero_rr", 64'(dut.rr_ptr), 64'd2);
    chk("zero_stall", 64'(stall_cnt), 64'd2);
    set_src(0, 1'b0, 5'd0, 32'h0);
    set_src(1, 1'b0, 5'd0, 32'h0);

    // Move rr_ptr to 1 with a lone src0 grant
    set_src(0, 1'b1, 5'd10, 32'h0A);
    #1 chk("prep_ready", 64'(req_ready), 64'b0001);
    tick();
    chk("prep_rr", 64'(dut.rr_ptr), 64'd1);
    set_src(0, 1'b0, 5'd0, 32'h0);

    // Fairness from rr_ptr=1
    set_src(0, 1'b1, 5'd4, 32'hF0);
    set_src(1, 1'b1, 5'd4, 32'hF1);
    set_src(3, 1'b1, 5'd6, 32'hF3);
    #1 chk("fair_c0_ready", 64'(req_ready), 64'b1010);
    tick();
    chk_p1("fair_c0", 1'b1, 5'd4, 32'hF1);
    chk_p2("fair_c0", 1'b1, 5'd6, 32'hF3);
    chk("fair_c0_rr", 64'(dut.rr_ptr), 64'd0);
    chk("fair_c0_stall", 64'(stall_cnt), 64'd3);
    set_src(1, 1'b0, 5'd0, 32'h0);
    set_src(3, 1'b1, 5'd6, 32'hF4);
    #1 chk("fair_c1_ready", 64'(req_ready), 64'b1001);
    tick();
    chk_p1("fair_c1", 1'b1, 5'd4, 32'hF0);
    chk_p2("fair_c1", 1'b1, 5'd6, 32'hF4);
    chk("fair_c1_rr", 64'(dut.rr_ptr), 64'd0);
    set_src(0, 1'b0, 5'd0, 32'h0);
    set_src(3, 1'b0, 5'd0, 32'h0);

    // Reset mid-stream with three pending requests
    set_src(0, 1'b1, 5'd1, 32'hB0);
    set_src(1, 1'b1, 5'd2, 32'hB1);
    set_src(2, 1'b1, 5'd3, 32'hB2);
    rst = 1'b1;
    #1 chk("mrst_ready", 64'(req_ready), 64'b0000);
    tick();
    chk_p1("mrst", 1'b0, 5'd0, 32'h0);
    chk("mrst_we2", 64'(we2), 64'd0);
    chk("mrst_stall", 64'(stall_cnt), 64'd0);
    chk("mrst_rr", 64'(dut.rr_ptr), 64'd0);
    rst = 1'b0;
    #1 chk("resume_c0_ready", 64'(req_ready), 64'b0011);
    tick();
    chk_p1("resume_c0", 1'b1, 5'd1, 32'hB0);
    chk_p2("resume_c0", 1'b1, 5'd2, 32'hB1);
    chk("resume_c0_rr", 64'(dut.rr_ptr), 64'd2);
    chk("resume_c0_stall", 64'(stall_cnt), 64'd1);
    set_src(0, 1'b0, 5'd0, 32'h0);
    set_src(1, 1'b0, 5'd0, 32'h0);
    #1 chk("resume_c1_ready", 64'(req_ready), 64'b0100);
    tick();
    chk_p1("resume_c1", 1'b1, 5'd3, 32'hB2);
    chk("resume_c1_we2", 64'(we2), 64'd0);
    chk("resume_c1_rr", 64'(dut.rr_ptr), 64'd3);
    set_src(2, 1'b0, 5'd0, 32'h0);

    // Stall counter saturation: two same-address sources held valid
    set_src(0, 1'b1, 5'd5, 32'h1);
    set_src(1, 1'b1, 5'd5, 32'h2);
    repeat (13) tick();
    chk("sat_pre", 64'(stall_cnt), 64'd14);
    repeat (7) tick();
    chk("sat_hold", 64'(stall_cnt), 64'hF);
    set_src(0, 1'b0, 5'd0, 32'h0);
    set_src(1, 1'b0, 5'd0, 32'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
